muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit; the execute-stage neighbour directly downstream of the register file.
- Consumes the two register read ports (RD1 → op_a, RD2 → op_b) and produces a result that the writeback path routes back to the register file WD port.
- The control unit holds the core stalled (PC and register file WE gated) while busy is high, then writes result when done pulses.

---
 rtl/muldiv_unit_pkg.sv | 30 +++
 rtl/muldiv_unit_if.sv | 34 +++
 rtl/mdu_sign_adjust.sv | 18 +
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_muldiv_unit.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
// Shared definitions for the iterative RV32M multiply/divide unit:
//   - funct3 operation encodings (MDU_MUL .. MDU_REMU)
//   - controller state encoding (IDLE, RUN, FIN)
//   - iteration counter width helper
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } mdu_state_e;

    // One extra bit so the counter can also represent WIDTH itself.
    function automatic int mdu_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
// Request/response bundle between the execute stage and the multiply/divide
// unit.
//   start   : request a new operation (taken only while busy is low)
//   funct3  : RV32M operation select
//   op_a    : rs1 value (multiplicand / dividend)
//   op_b    : rs2 value (multiplier / divisor)
//   busy    : operation in progress
//   done    : one-cycle pulse, result valid
//   result  : final value, held until the next completed operation
// master = requester (control / execute), slave = muldiv_unit.
// -----------------------------------------------------------------------------
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, funct3, op_a, op_b,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b,
        output busy, done, result
    );
endinterface

// File: rtl/mdu_sign_adjust.sv
// -----------------------------------------------------------------------------
// mdu_sign_adjust
// Combinational conditional two's-complement negate.
//   neg_i : 1 = output the negation of val_i, 0 = pass through
//   val_i : input value (W bits)
//   val_o : adjusted value (W bits)
// Negating the most-negative value yields the same bit pattern, which read as
// unsigned is exactly its magnitude.
// -----------------------------------------------------------------------------
module mdu_sign_adjust #(
    parameter int W = 32
) (
    input  logic         neg_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] val_o
);
    assign val_o = neg_i ? (~val_i + W'(1)) : val_i;
endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit. Radix-2 shift-add multiply and
// restoring divide on operand magnitudes, one bit per RUN cycle, signs applied
// in FIN. Divide-by-zero and signed overflow skip RUN entirely.
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset, clears all state
//   mdu   : request/response bundle (slave side), see muldiv_unit_if
// Timing (accept edge = cycle 0): busy in cycles 1..WIDTH+1, done/result in
// cycle WIDTH+2; special cases: busy in cycle 1, done in cycle 2.
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  mdu
);
    localparam int CW = mdu_cnt_width(WIDTH);

    mdu_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [2:0]         op_q;
    logic [2*WIDTH-1:0] acc_q;          // mul: {partial, multiplier}; div: low half = dividend/quotient
    logic [WIDTH:0]     rem_q;          // partial remainder incl. borrow headroom
    logic [WIDTH-1:0]   opnd_q;         // mul: |multiplicand|, div: |divisor|
    logic               neg_q;          // product / quotient sign
    logic               rneg_q;         // remainder sign (dividend sign)
    logic               special_q;
    logic [WIDTH-1:0]   special_res_q;
    logic [WIDTH-1:0]   result_q;
    logic               done_q;

    // ---------------- accept-time decode ----------------
    logic             accept, is_div_in, is_rem_in, sgn_a_op, sgn_b_op;
    logic             a_neg, b_neg, div_zero, div_ovf;
    logic [WIDTH-1:0] mag_a, mag_b, special_val;

    assign accept    = (state_q == IDLE) && mdu.start;
    assign is_div_in = mdu.funct3 inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
    assign is_rem_in = mdu.funct3 inside {MDU_REM, MDU_REMU};
    assign sgn_a_op  = mdu.funct3 inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
    assign sgn_b_op  = mdu.funct3 inside {MDU_MULH, MDU_DIV, MDU_REM};
    assign a_neg     = sgn_a_op & mdu.op_a[WIDTH-1];
    assign b_neg     = sgn_b_op & mdu.op_b[WIDTH-1];
    assign div_zero  = is_div_in && (mdu.op_b == '0);
    assign div_ovf   = (mdu.funct3 inside {MDU_DIV, MDU_REM})
                       && (mdu.op_a == {1'b1, {(WIDTH-1){1'b0}}})
                       && (mdu.op_b == '1);
    // Divide-by-zero takes precedence over overflow (0x80..0 / 0 is div-by-zero).
    assign special_val = div_zero ? (is_rem_in ? mdu.op_a : '1)
                                  : (is_rem_in ? '0 : mdu.op_a);

    mdu_sign_adjust #(.W(WIDTH)) u_mag_a (.neg_i(a_neg), .val_i(mdu.op_a), .val_o(mag_a));
    mdu_sign_adjust #(.W(WIDTH)) u_mag_b (.neg_i(b_neg), .val_i(mdu.op_b), .val_o(mag_b));

    // ---------------- iteration datapath ----------------
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_shift, div_diff;
    logic               div_borrow;

    assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift  = {rem_q, acc_q[WIDTH-1]};
    assign div_diff   = div_shift - {2'b00, opnd_q};
    assign div_borrow = div_diff[WIDTH+1];

    // ---------------- final sign fix-up ----------------
    logic [2*WIDTH-1:0] fix_in, prod_fix;
    logic [WIDTH-1:0]   rem_fix, final_val;

    assign fix_in = op_q[2] ? {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} : acc_q;

    mdu_sign_adjust #(.W(2*WIDTH)) u_fix_pq  (.neg_i(neg_q),  .val_i(fix_in),             .val_o(prod_fix));
    mdu_sign_adjust #(.W(WIDTH))   u_fix_rem (.neg_i(rneg_q), .val_i(rem_q[WIDTH-1:0]),   .val_o(rem_fix));

    always_comb begin
        final_val = prod_fix[WIDTH-1:0];            // MUL low half, DIV/DIVU quotient
        if (special_q)
            final_val = special_res_q;
        else if (op_q inside {MDU_REM, MDU_REMU})
            final_val = rem_fix;
        else if (op_q inside {MDU_MULH, MDU_MULHSU, MDU_MULHU})
            final_val = prod_fix[2*WIDTH-1:WIDTH];
    end

    // ---------------- controller ----------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (div_zero || div_ovf) ? FIN : RUN;
            RUN:     if (cnt_q == CW'(WIDTH-1)) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            op_q          <= '0;
            acc_q         <= '0;
            rem_q         <= '0;
            opnd_q        <= '0;
            neg_q         <= 1'b0;
            rneg_q        <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= '0;
            result_q      <= '0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    op_q          <= mdu.funct3;
                    cnt_q         <= '0;
                    rem_q         <= '0;
                    neg_q         <= a_neg ^ b_neg;
                    rneg_q        <= a_neg;
                    special_q     <= div_zero || div_ovf;
                    special_res_q <= special_val;
                    // Iterated operand sits in acc low half; the other is held in opnd_q.
                    opnd_q        <= is_div_in ? mag_b : mag_a;
                    acc_q         <= {{WIDTH{1'b0}}, (is_div_in ? mag_a : mag_b)};
                end
                RUN: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (op_q[2]) begin
                        rem_q              <= div_borrow ? div_shift[WIDTH:0] : div_diff[WIDTH:0];
                        acc_q[WIDTH-1:0]   <= {acc_q[WIDTH-2:0], ~div_borrow};
                    end else begin
                        acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
                    end
                end
                FIN: begin
                    result_q <= final_val;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mdu.busy   = (state_q != IDLE);
    assign mdu.done   = done_q;
    assign mdu.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request before an edge; that edge is the accept edge (cycle 0).
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.op_a   = a;
        bus.op_b   = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Sample at each negedge after the accept edge: first sample is cycle 1.
    // inj1/inj2 > 0: pulse a competing start during those cycles.
    task automatic wait_done(input int inj1, input int inj2,
                             output int cyc, output int busy_n, output logic busy_at_done);
        cyc = -1;
        busy_n = 0;
        busy_at_done = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                cyc = k;
                busy_at_done = bus.busy;
                break;
            end
            if (bus.busy === 1'b1) busy_n++;
            if (inj1 > 0) begin
                if (k == inj1 || k == inj2) begin
                    bus.start  = 1'b1;
                    bus.funct3 = MDU_DIVU;
                    bus.op_a   = 32'd100;
                    bus.op_b   = 32'd7;
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        if (inj1 > 0) bus.start = 1'b0;
    endtask

    task automatic check_done(input string tag, input logic [31:0] exp_res, input int exp_cyc,
                              input int cyc, input int busy_n, input logic busy_at_done);
        check({tag, " done_cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, " busy_cycles"}, 32'(busy_n), 32'(exp_cyc - 1));
        check({tag, " busy_at_done"}, {31'b0, busy_at_done}, 32'd0);
        check({tag, " result"}, bus.result, exp_res);
        $display("txn %-8s result=%h done_cycle=%0d busy_cycles=%0d", tag, bus.result, cyc, busy_n);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_cyc);
        int cyc, busy_n;
        logic bz;
        start_op(f, a, b);
        wait_done(0, 0, cyc, busy_n, bz);
        check_done(tag, exp_res, exp_cyc, cyc, busy_n, bz);
    endtask

    initial begin
        int   cyc, busy_n;
        logic bz;

        bus.start  = 1'b0;
        bus.funct3 = 3'b000;
        bus.op_a   = '0;
        bus.op_b   = '0;

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset busy", {31'b0, bus.busy}, 32'd0);
        check("reset done", {31'b0, bus.done}, 32'd0);
        check("reset result", bus.result, 32'd0);
        $display("txn reset    busy=%b done=%b result=%h", bus.busy, bus.done, bus.result);
        reset = 1'b0;

        // Normal operations: done in cycle 34
        run_op("MUL",    MDU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        run_op("MULH",   MDU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34);
        run_op("MULHU",  MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        run_op("MULHSU", MDU_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34);
        run_op("DIV",    MDU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
        run_op("REM",    MDU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
        run_op("DIVU",   MDU_DIVU,   32'd100,      32'd7,        32'd14,       34);
        run_op("REMU",   MDU_REMU,   32'd100,      32'd7,        32'd2,        34);

        // Special cases: done in cycle 2
        run_op("DIVU/0", MDU_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 2);
        run_op("REM/0",  MDU_REM,    32'd5,        32'd0,        32'd5,        2);
        run_op("DIVovf", MDU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
        run_op("REMovf", MDU_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        2);

        // Start pulses during busy are ignored and not queued
        start_op(MDU_MUL, 32'd3, 32'd5);
        wait_done(5, 20, cyc, busy_n, bz);
        check_done("MUL+ign", 32'd15, 34, cyc, busy_n, bz);
        @(negedge clk);
        check("no queued op", {31'b0, bus.busy}, 32'd0);

        // start held across the done cycle: back-to-back accept
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = MDU_MUL;
        bus.op_a   = 32'd6;
        bus.op_b   = 32'd7;
        @(posedge clk);
        #1;
        bus.funct3 = MDU_DIVU;
        bus.op_a   = 32'd100;
        bus.op_b   = 32'd7;
        wait_done(0, 0, cyc, busy_n, bz);
        check_done("B2B-1", 32'd42, 34, cyc, busy_n, bz);
        @(posedge clk);          // edge ending the done cycle accepts the second op
        #1 bus.start = 1'b0;
        wait_done(0, 0, cyc, busy_n, bz);
        check_done("B2B-2", 32'd14, 34, cyc, busy_n, bz);

        // Reset mid-operation
        start_op(MDU_DIVU, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        check("midop busy", {31'b0, bus.busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst busy", {31'b0, bus.busy}, 32'd0);
        check("rst done", {31'b0, bus.done}, 32'd0);
        check("rst result", bus.result, 32'd0);
        $display("txn midreset busy=%b done=%b result=%h", bus.busy, bus.done, bus.result);
        reset = 1'b0;
        run_op("MUL3x4", MDU_MUL, 32'd3, 32'd4, 32'd12, 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
